// File: rtl/spinnaker_fpgas_reg_bank_pkg.sv
// Shared constants for the SpiNNaker FPGA peek/poke register bank:
// register indices, the unmapped-read marker and the default version word.
package spinnaker_fpgas_reg_bank_pkg;

    localparam int unsigned IDX_VERSION   = 0;
    localparam int unsigned IDX_SCRATCH   = 1;
    localparam int unsigned IDX_CTRL      = 2;
    localparam int unsigned IDX_STATUS    = 3;
    localparam int unsigned IDX_EVT_COUNT = 4;
    localparam int unsigned IDX_SW_RESET  = 5;
    localparam int unsigned NUM_REGS      = 6;

    localparam logic [31:0] BAD_ADDR_VALUE  = 32'hBAD0_ADD0;
    localparam logic [31:0] DEFAULT_VERSION = 32'h0001_0000;

    typedef enum logic [2:0] {
        REG_VERSION   = 3'(IDX_VERSION),
        REG_SCRATCH   = 3'(IDX_SCRATCH),
        REG_CTRL      = 3'(IDX_CTRL),
        REG_STATUS    = 3'(IDX_STATUS),
        REG_EVT_COUNT = 3'(IDX_EVT_COUNT),
        REG_SW_RESET  = 3'(IDX_SW_RESET),
        REG_NONE      = 3'd6
    } reg_sel_e;

    typedef enum logic {
        PG_IDLE  = 1'b0,
        PG_PULSE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/spinnaker_fpgas_reg_bank_if.sv
// Peek/poke bus between the SPI slave (master side) and the register bank.
interface spinnaker_fpgas_reg_bank_if #(
    parameter int ADDR_BITS = 32,
    parameter int VAL_BITS  = 32
);
    logic [ADDR_BITS-1:0] ADDRESS_IN;
    logic                 READ_IN;
    logic                 WRITE_IN;
    logic [VAL_BITS-1:0]  WRITE_VALUE_IN;
    logic [VAL_BITS-1:0]  READ_VALUE_OUT;

    modport master (
        output ADDRESS_IN, READ_IN, WRITE_IN, WRITE_VALUE_IN,
        input  READ_VALUE_OUT
    );

    modport slave (
        input  ADDRESS_IN, READ_IN, WRITE_IN, WRITE_VALUE_IN,
        output READ_VALUE_OUT
    );
endinterface

// File: rtl/spinnaker_fpgas_pulse_gen.sv
// Retriggerable fixed-length pulse generator driven by a down-counter.
// state | meaning
// IDLE  | output low, waiting for trigger
// PULSE | output high, counter running down to terminal count
module spinnaker_fpgas_pulse_gen
    import spinnaker_fpgas_reg_bank_pkg::*;
#(
    parameter int LENGTH = 16
) (
    input  logic CLK_IN,
    input  logic RESET_IN,
    input  logic TRIGGER_IN,
    output logic PULSE_OUT
);

    localparam int CNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LENGTH - 1);

    pulse_state_e     state;
    logic [CNT_W-1:0] count;

    // A trigger always reloads, so a retrigger mid-pulse stretches it by a full LENGTH.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state     <= PG_IDLE;
            count     <= '0;
            PULSE_OUT <= 1'b0;
        end else begin
            case (state)
                PG_IDLE: begin
                    if (TRIGGER_IN) begin
                        state     <= PG_PULSE;
                        count     <= RELOAD;
                        PULSE_OUT <= 1'b1;
                    end
                end
                PG_PULSE: begin
                    if (TRIGGER_IN) begin
                        count <= RELOAD;
                    end else if (count == '0) begin
                        state     <= PG_IDLE;
                        PULSE_OUT <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state     <= PG_IDLE;
                    count     <= '0;
                    PULSE_OUT <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/spinnaker_fpgas_reg_bank.sv
// Peek/poke register bank: version, scratch, control, sticky event status,
// event counter and a software-reset pulse for downstream logic.
module spinnaker_fpgas_reg_bank
    import spinnaker_fpgas_reg_bank_pkg::*;
#(
    parameter int               ADDR_BITS       = 32,
    parameter int               VAL_BITS        = 32,
    parameter int               NUM_EVENTS      = 8,
    parameter logic [VAL_BITS-1:0] VERSION      = VAL_BITS'(DEFAULT_VERSION),
    parameter int               SW_RESET_CYCLES = 16
) (
    input  logic                    CLK_IN,
    input  logic                    RESET_IN,
    spinnaker_fpgas_reg_bank_if.slave bus,
    input  logic [NUM_EVENTS-1:0]   EVENT_IN,
    output logic [VAL_BITS-1:0]     CTRL_OUT,
    output logic                    SW_RESET_OUT
);

    localparam int IDX_W = ADDR_BITS - 2;

    logic [IDX_W-1:0]      idx;
    reg_sel_e              sel;
    logic                  rd_en;
    logic                  wr_en;
    logic                  sw_trigger;
    logic [VAL_BITS-1:0]   scratch_q;
    logic [VAL_BITS-1:0]   ctrl_q;
    logic [NUM_EVENTS-1:0] status_q;
    logic [NUM_EVENTS-1:0] status_clr;
    logic [VAL_BITS-1:0]   evt_count_q;
    logic [VAL_BITS-1:0]   rdata;
    logic                  unused_addr;

    assign idx         = bus.ADDRESS_IN[ADDR_BITS-1:2];
    assign unused_addr = ^bus.ADDRESS_IN[1:0];

    always_comb begin
        sel = REG_NONE;
        if (idx < IDX_W'(NUM_REGS))
            sel = reg_sel_e'(idx[2:0]);
    end

    // A simultaneous read and write is treated as a write alone.
    assign wr_en      = bus.WRITE_IN;
    assign rd_en      = bus.READ_IN && !bus.WRITE_IN;
    assign sw_trigger = wr_en && (sel == REG_SW_RESET) && bus.WRITE_VALUE_IN[0];
    assign status_clr = (wr_en && (sel == REG_STATUS)) ? bus.WRITE_VALUE_IN[NUM_EVENTS-1:0]
                                                       : '0;

    always_comb begin
        rdata = VAL_BITS'(BAD_ADDR_VALUE);
        case (sel)
            REG_VERSION:   rdata = VERSION;
            REG_SCRATCH:   rdata = scratch_q;
            REG_CTRL:      rdata = ctrl_q;
            REG_STATUS:    rdata = VAL_BITS'(status_q);
            REG_EVT_COUNT: rdata = evt_count_q;
            REG_SW_RESET:  rdata = '0;
            default:       rdata = VAL_BITS'(BAD_ADDR_VALUE);
        endcase
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            bus.READ_VALUE_OUT <= '0;
            scratch_q          <= '0;
            ctrl_q             <= '0;
            status_q           <= '0;
            evt_count_q        <= '0;
        end else begin
            if (rd_en)
                bus.READ_VALUE_OUT <= rdata;
            if (wr_en && (sel == REG_SCRATCH))
                scratch_q <= bus.WRITE_VALUE_IN;
            if (wr_en && (sel == REG_CTRL))
                ctrl_q <= bus.WRITE_VALUE_IN;
            // Set has priority over clear so an event arriving during a W1C is not lost.
            status_q <= (status_q & ~status_clr) | EVENT_IN;
            if (rd_en && (sel == REG_EVT_COUNT))
                evt_count_q <= EVENT_IN[0] ? VAL_BITS'(1) : '0;
            else if (EVENT_IN[0] && (evt_count_q != '1))
                evt_count_q <= evt_count_q + VAL_BITS'(1);
        end
    end

    assign CTRL_OUT = ctrl_q;

    spinnaker_fpgas_pulse_gen #(
        .LENGTH (SW_RESET_CYCLES)
    ) u_pulse_gen (
        .CLK_IN     (CLK_IN),
        .RESET_IN   (RESET_IN),
        .TRIGGER_IN (sw_trigger),
        .PULSE_OUT  (SW_RESET_OUT)
    );

endmodule

// File: tb/tb_spinnaker_fpgas_reg_bank.sv
// Self-checking bench for the peek/poke register bank and its software-reset pulse.
module tb_spinnaker_fpgas_reg_bank;
    import spinnaker_fpgas_reg_bank_pkg::*;

    logic        CLK_IN = 1'b0;
    logic        RESET_IN = 1'b1;
    logic [7:0]  EVENT_IN = '0;
    logic [31:0] CTRL_OUT;
    logic        SW_RESET_OUT;

    spinnaker_fpgas_reg_bank_if #(.ADDR_BITS(32), .VAL_BITS(32)) bus ();

    spinnaker_fpgas_reg_bank dut (
        .CLK_IN       (CLK_IN),
        .RESET_IN     (RESET_IN),
        .bus          (bus.slave),
        .EVENT_IN     (EVENT_IN),
        .CTRL_OUT     (CTRL_OUT),
        .SW_RESET_OUT (SW_RESET_OUT)
    );

    always #5 CLK_IN = ~CLK_IN;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = '0;

    task automatic cyc();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] val,
                             input logic [7:0] ev = 8'h00);
        bus.ADDRESS_IN     = addr;
        bus.WRITE_VALUE_IN = val;
        bus.WRITE_IN       = 1'b1;
        EVENT_IN           = ev;
        cyc();
        bus.WRITE_IN = 1'b0;
        EVENT_IN     = 8'h00;
    endtask

    // Expected value is queued with the strobe and retired when the registered data appears.
    task automatic bus_read(input string name, input logic [31:0] addr,
                            input logic [31:0] exp, input logic [7:0] ev = 8'h00);
        logic [31:0] want;
        bus.ADDRESS_IN = addr;
        bus.READ_IN    = 1'b1;
        EVENT_IN       = ev;
        exp_q.push_back(exp);
        cyc();
        bus.READ_IN = 1'b0;
        EVENT_IN    = 8'h00;
        want = exp_q.pop_front();
        checks++;
        if (bus.READ_VALUE_OUT !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, bus.READ_VALUE_OUT, want);
        end
        last_rd = want;
    endtask

    task automatic test_reset();
        RESET_IN = 1'b1;
        repeat (2) cyc();
        checks++;
        if (bus.READ_VALUE_OUT !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", bus.READ_VALUE_OUT);
        end
        checks++;
        if (CTRL_OUT !== 32'h0) begin
            errors++; $display("FAIL reset_ctrl: got %h expected 0", CTRL_OUT);
        end
        checks++;
        if (SW_RESET_OUT !== 1'b0) begin
            errors++; $display("FAIL reset_swr: got %b expected 0", SW_RESET_OUT);
        end
        @(negedge CLK_IN);
        RESET_IN = 1'b0;
        cyc();
        bus_read("reset_version", 32'd0,  32'h0001_0000);
        bus_read("reset_scratch", 32'd4,  32'h0);
        bus_read("reset_status",  32'd12, 32'h0);
        bus_read("reset_evt",     32'd16, 32'h0);
        bus_read("reset_swreg",   32'd20, 32'h0);
    endtask

    task automatic test_scratch_ctrl();
        bus_write(32'd4, 32'hCAFE_F00D);
        bus_read("scratch_rd", 32'd4, 32'hCAFE_F00D);
        cyc();
        checks++;
        if (bus.READ_VALUE_OUT !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL rdata_hold: got %h expected cafef00d", bus.READ_VALUE_OUT);
        end
        bus_read("scratch_lowbits", 32'd7, 32'hCAFE_F00D);
        bus_write(32'd8, 32'hA5A5_0001);
        checks++;
        if (CTRL_OUT !== 32'hA5A5_0001) begin
            errors++; $display("FAIL ctrl_out: got %h expected a5a50001", CTRL_OUT);
        end
        bus_read("ctrl_rd", 32'd8, 32'hA5A5_0001);
    endtask

    task automatic test_status();
        EVENT_IN = 8'h05;
        cyc();
        EVENT_IN = 8'h00;
        bus_read("status_set", 32'd12, 32'h5);
        bus_write(32'd12, 32'h1, 8'h01);
        bus_read("status_set_wins", 32'd12, 32'h5);
        bus_write(32'd12, 32'h5);
        bus_read("status_w1c", 32'd12, 32'h0);
        EVENT_IN = 8'h82;
        cyc();
        EVENT_IN = 8'h00;
        bus_read("status_hi", 32'd12, 32'h82);
        bus_write(32'd12, 32'hFFFF_FFFF);
        bus_read("status_clr_all", 32'd12, 32'h0);
    endtask

    task automatic test_evt_count();
        // Two EVENT_IN[0] pulses were produced by the status scenario.
        bus_read("evt_prior", 32'd16, 32'd2);
        bus_read("evt_cleared", 32'd16, 32'd0);
        for (int i = 0; i < 3; i++) begin
            EVENT_IN = 8'h01;
            cyc();
            EVENT_IN = 8'h00;
            cyc();
        end
        bus_read("evt_three", 32'd16, 32'd3, 8'h01);
        bus_read("evt_after_ev", 32'd16, 32'd1);
        bus_read("evt_zero", 32'd16, 32'd0);
    endtask

    task automatic test_bad_addr();
        bus_read("bad_addr", 32'd36, 32'hBAD0_ADD0);
        bus_write(32'd36, 32'h1111_2222);
        bus_read("bad_wr_noeffect", 32'd4, 32'hCAFE_F00D);
        bus_write(32'd0, 32'hFFFF_FFFF);
        bus_read("version_ro", 32'd0, 32'h0001_0000);
        bus_write(32'd16, 32'h0000_00FF);
        bus_read("evt_ro", 32'd16, 32'h0);
    endtask

    task automatic test_rw_both();
        logic [31:0] prev;
        bus_read("scratch_pre", 32'd4, 32'hCAFE_F00D);
        prev = last_rd;
        bus.ADDRESS_IN     = 32'd4;
        bus.WRITE_VALUE_IN = 32'h1234_5678;
        bus.READ_IN        = 1'b1;
        bus.WRITE_IN       = 1'b1;
        cyc();
        bus.READ_IN  = 1'b0;
        bus.WRITE_IN = 1'b0;
        checks++;
        if (bus.READ_VALUE_OUT !== prev) begin
            errors++; $display("FAIL rw_both_rdata: got %h expected %h", bus.READ_VALUE_OUT, prev);
        end
        bus_read("rw_both_written", 32'd4, 32'h1234_5678);
    endtask

    task automatic test_pulse();
        int  n;
        bit  retrig;
        bus_write(32'd20, 32'h0000_0002);
        cyc();
        checks++;
        if (SW_RESET_OUT !== 1'b0) begin
            errors++; $display("FAIL swr_bit0_zero: got %b expected 0", SW_RESET_OUT);
        end
        bus_write(32'd20, 32'h1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (SW_RESET_OUT !== 1'b1) break;
            n++;
            cyc();
        end
        checks++;
        if (n != 16) begin
            errors++; $display("FAIL swr_len: got %0d cycles expected 16", n);
        end
        bus_write(32'd20, 32'h1);
        n = 0;
        retrig = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (SW_RESET_OUT !== 1'b1) break;
            n++;
            if (n == 10 && !retrig) begin
                retrig = 1'b1;
                bus_write(32'd20, 32'h1);
            end else begin
                cyc();
            end
        end
        checks++;
        if (n != 26) begin
            errors++; $display("FAIL swr_retrig_len: got %0d cycles expected 26", n);
        end
        bus_read("swr_reads_zero", 32'd20, 32'h0);
        bus_read("scratch_survives_swr", 32'd4, 32'h1234_5678);
    endtask

    task automatic test_reset_mid_pulse();
        bus_write(32'd20, 32'h1);
        cyc();
        cyc();
        checks++;
        if (SW_RESET_OUT !== 1'b1) begin
            errors++; $display("FAIL swr_before_rst: got %b expected 1", SW_RESET_OUT);
        end
        #2;
        RESET_IN = 1'b1;
        #1;
        checks++;
        if (SW_RESET_OUT !== 1'b0) begin
            errors++; $display("FAIL rst_mid_swr: got %b expected 0", SW_RESET_OUT);
        end
        checks++;
        if (CTRL_OUT !== 32'h0) begin
            errors++; $display("FAIL rst_mid_ctrl: got %h expected 0", CTRL_OUT);
        end
        checks++;
        if (bus.READ_VALUE_OUT !== 32'h0) begin
            errors++; $display("FAIL rst_mid_rdata: got %h expected 0", bus.READ_VALUE_OUT);
        end
        @(negedge CLK_IN);
        RESET_IN = 1'b0;
        repeat (3) cyc();
        checks++;
        if (SW_RESET_OUT !== 1'b0) begin
            errors++; $display("FAIL rst_mid_swr_stays: got %b expected 0", SW_RESET_OUT);
        end
        bus_read("rst_mid_scratch", 32'd4,  32'h0);
        bus_read("rst_mid_status",  32'd12, 32'h0);
        bus_read("rst_mid_evt",     32'd16, 32'h0);
    endtask

    initial begin
        bus.ADDRESS_IN     = '0;
        bus.READ_IN        = 1'b0;
        bus.WRITE_IN       = 1'b0;
        bus.WRITE_VALUE_IN = '0;
        test_reset();
        test_scratch_ctrl();
        test_status();
        test_evt_count();
        test_bad_addr();
        test_rw_both();
        test_pulse();
        test_reset_mid_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
